// File: rtl/divider_8_bit_pkg.sv
// Shared constants for the 8-bit restoring divider: operand width and FSM encoding.
package divider_8_bit_pkg;

  localparam int WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/divider_8_bit_subtractor.sv
// Combinational ripple-carry subtractor d = a - b built from full adders (a + ~b + 1).
module subtractor_8_bit
  import divider_8_bit_pkg::*;
(
  output logic [WIDTH-1:0] d,
  output logic             borrow,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b
);

  logic [WIDTH:0] carry_s;

  assign carry_s[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a     (a[i]),
      .b     (~b[i]),
      .c_in  (carry_s[i]),
      .sum   (d[i]),
      .c_out (carry_s[i+1])
    );
  end

  // No carry out of the top stage means a < b.
  assign borrow = ~carry_s[WIDTH];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the ripple-carry arithmetic.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/divider_8_bit.sv
// Sequential 8-bit unsigned restoring divider, one quotient bit per clock, start/done handshake.
module divider_8_bit
  import divider_8_bit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  div_state_e       state_q, state_d;
  logic [2:0]       count_q, count_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] r_shift_s;
  logic [WIDTH-1:0] trial_s;
  logic             borrow_s;
  logic             hi_s;
  logic             take_s;
  logic [WIDTH-1:0] r_next_s;
  logic [WIDTH-1:0] q_next_s;

  // hi is the bit shifted out of R; when set, the 9-bit value exceeds any divisor.
  assign hi_s      = r_q[WIDTH-1];
  assign r_shift_s = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

  subtractor_8_bit u_sub (
    .d      (trial_s),
    .borrow (borrow_s),
    .a      (r_shift_s),
    .b      (divisor_q)
  );

  assign take_s   = hi_s | ~borrow_s;
  assign r_next_s = take_s ? trial_s : r_shift_s;
  assign q_next_s = {q_q[WIDTH-2:0], take_s};

  // Next-state and datapath/output update logic.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    r_d         = r_q;
    q_d         = q_q;
    divisor_d   = divisor_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          divisor_d = divisor;
          if (divisor != 8'd0) begin
            state_d = RUN;
            count_d = 3'd0;
            r_d     = 8'd0;
            q_d     = dividend;
            busy_d  = 1'b1;
            dbz_d   = 1'b0;
          end else begin
            state_d     = DONE;
            quotient_d  = 8'hFF;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            done_d      = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        r_d     = r_next_s;
        q_d     = q_next_s;
        count_d = count_q + 3'd1;
        if (count_q == 3'd7) begin
          state_d     = DONE;
          quotient_d  = q_next_s;
          remainder_d = r_next_s;
          done_d      = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= 3'd0;
      r_q         <= 8'd0;
      q_q         <= 8'd0;
      divisor_q   <= 8'd0;
      quotient_q  <= 8'd0;
      remainder_q <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      r_q         <= r_d;
      q_q         <= q_d;
      divisor_q   <= divisor_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_8_bit.sv
// Self-checking bench for divider_8_bit: directed corner cases plus a random sweep vs. integer division.
module tb_divider_8_bit;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int errors;
  int checks;
  int cyc;
  logic [7:0] exp_q;
  logic [7:0] exp_r;
  logic       exp_z;
  int         exp_lat;

  divider_8_bit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue an accepted start and compute the expected outcome with plain arithmetic.
  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (b == 8'd0) begin
      exp_q   = 8'hFF;
      exp_r   = a;
      exp_z   = 1'b1;
      exp_lat = 1;
    end else begin
      exp_q   = 8'(a / b);
      exp_r   = 8'(a % b);
      exp_z   = 1'b0;
      exp_lat = 9;
    end
    tick();
    start = 1'b0;
    cyc   = 1;
  endtask

  // Wait (bounded) for done, checking busy on the way, then check latency and results.
  task automatic finish_op(input string tag);
    while (done !== 1'b1 && cyc < 20) begin
      chk({tag, "_busy"}, busy, 1'b1);
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, cyc, exp_lat);
    chk({tag, "_busy_at_done"}, busy, 1'b0);
    chk({tag, "_quotient"}, quotient, exp_q);
    chk({tag, "_remainder"}, remainder, exp_r);
    chk({tag, "_dbz"}, div_by_zero, exp_z);
  endtask

  task automatic done_width(input string tag);
    tick();
    chk({tag, "_done_width"}, done, 1'b0);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    repeat (2) tick();
    chk("reset_q", quotient, 8'd0);
    chk("reset_r", remainder, 8'd0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_dbz", div_by_zero, 1'b0);
    rst = 1'b0;
    tick();

    launch(8'd200, 8'd7);
    finish_op("d200_7");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_q", quotient, 8'd28);
      chk("hold_r", remainder, 8'd4);
      chk("hold_done", done, 1'b0);
      chk("hold_busy", busy, 1'b0);
    end

    launch(8'd255, 8'd1);   finish_op("d255_1");   done_width("d255_1");
    launch(8'd255, 8'd255); finish_op("d255_255"); done_width("d255_255");
    launch(8'd5, 8'd9);     finish_op("d5_9");     done_width("d5_9");
    launch(8'd0, 8'd3);     finish_op("d0_3");     done_width("d0_3");
    launch(8'd255, 8'd128); finish_op("d255_128"); done_width("d255_128");

    launch(8'd77, 8'd0);
    finish_op("d77_0");
    done_width("d77_0");
    chk("dbz_held", div_by_zero, 1'b1);
    launch(8'd10, 8'd3);
    chk("dbz_cleared_on_start", div_by_zero, 1'b0);
    finish_op("d10_3");
    done_width("d10_3");

    // Start during RUN must be ignored.
    launch(8'd100, 8'd9);
    repeat (2) begin
      tick();
      cyc++;
    end
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    tick();
    cyc++;
    start = 1'b0;
    finish_op("ignored_start");
    // Back-to-back start in the DONE cycle.
    launch(8'd50, 8'd5);
    chk("b2b_busy", busy, 1'b1);
    finish_op("b2b_50_5");
    done_width("b2b_50_5");

    // Reset in mid-run.
    launch(8'd200, 8'd7);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_q", quotient, 8'd0);
    chk("midrst_r", remainder, 8'd0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_dbz", div_by_zero, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("midrst_no_done", done, 1'b0);
      chk("midrst_idle_busy", busy, 1'b0);
    end
    launch(8'd9, 8'd2);
    finish_op("d9_2");
    done_width("d9_2");

    for (int n = 0; n < 1000; n++) begin
      logic [7:0] a;
      logic [7:0] b;
      a = 8'($urandom_range(0, 255));
      b = (n % 50 == 7) ? 8'd0 : 8'($urandom_range(0, 255));
      launch(a, b);
      finish_op("rand");
      done_width("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
